// File: rtl/alu_result_buffer.sv
// Two-entry skid buffer that registers ALU results (result, flags, op code) toward writeback.
// Optional build macro ALU_RESULT_BUFFER_OVF_DROP_EN: ADD/SUB entries that overflowed are consumed but not stored.
module alu_result_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   ALUctl,
    input  logic [W-1:0] ALUout,
    input  logic         Overflow,
    input  logic         Zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [3:0]   out_ctl,
    output logic         out_overflow,
    output logic         out_zero,
    output logic         sticky_ovf,
    input  logic         sticky_clr,
    output logic [15:0]  result_count
);

    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic           in_ready_q, in_ready_d;
    logic           sticky_q, sticky_d;
    logic [15:0]    count_q, count_d;

    logic [3:0]     main_ctl_q, skid_ctl_q;
    logic [W-1:0]   main_res_q, skid_res_q;
    logic           main_ovf_q, skid_ovf_q;
    logic           main_zero_q, skid_zero_q;

    logic           accept_s, deliver_s, arith_ovf_s, drop_s, store_s;
    logic           load_main_s, main_from_skid_s, load_skid_s;
    logic           out_valid_s;

    function automatic logic is_arith_ovf(input logic [3:0] ctl, input logic ovf);
        return ovf && ((ctl == CTL_ADD) || (ctl == CTL_SUB));
    endfunction

    assign accept_s    = in_valid & in_ready_q;
    assign deliver_s   = out_valid_s & out_ready;
    assign arith_ovf_s = is_arith_ovf(ALUctl, Overflow);
`ifdef ALU_RESULT_BUFFER_OVF_DROP_EN
    assign drop_s      = accept_s & arith_ovf_s;
`else
    assign drop_s      = 1'b0;
`endif
    assign store_s     = accept_s & ~drop_s;

    // State register plus registered in_ready (held low throughout reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state and data-steering decisions.
    always_comb begin
        state_d          = state_q;
        load_main_s      = 1'b0;
        main_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (store_s) begin
                    state_d     = ST_ONE;
                    load_main_s = 1'b1;
                end else begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (store_s && !deliver_s) begin
                    state_d     = ST_TWO;
                    load_skid_s = 1'b1;
                end else if (store_s && deliver_s) begin
                    state_d     = ST_ONE;
                    load_main_s = 1'b1;
                end else if (deliver_s) begin
                    state_d     = ST_EMPTY;
                end else begin
                    state_d     = ST_ONE;
                end
            end
            ST_TWO: begin
                if (deliver_s) begin
                    state_d          = ST_ONE;
                    main_from_skid_s = 1'b1;
                end else begin
                    state_d          = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Output decode; in_ready is computed from the next state so it is registered.
    always_comb begin
        out_valid_s = 1'b0;
        in_ready_d  = (state_d != ST_TWO);
        case (state_q)
            ST_EMPTY: out_valid_s = 1'b0;
            ST_ONE:   out_valid_s = 1'b1;
            ST_TWO:   out_valid_s = 1'b1;
            default:  out_valid_s = 1'b0;
        endcase
    end

    // Head (main) entry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctl_q  <= 4'b0000;
            main_res_q  <= {W{1'b0}};
            main_ovf_q  <= 1'b0;
            main_zero_q <= 1'b0;
        end else if (main_from_skid_s) begin
            main_ctl_q  <= skid_ctl_q;
            main_res_q  <= skid_res_q;
            main_ovf_q  <= skid_ovf_q;
            main_zero_q <= skid_zero_q;
        end else if (load_main_s) begin
            main_ctl_q  <= ALUctl;
            main_res_q  <= ALUout;
            main_ovf_q  <= Overflow;
            main_zero_q <= Zero;
        end
    end

    // Skid entry register, filled only when the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ctl_q  <= 4'b0000;
            skid_res_q  <= {W{1'b0}};
            skid_ovf_q  <= 1'b0;
            skid_zero_q <= 1'b0;
        end else if (load_skid_s) begin
            skid_ctl_q  <= ALUctl;
            skid_res_q  <= ALUout;
            skid_ovf_q  <= Overflow;
            skid_zero_q <= Zero;
        end
    end

    // Sticky overflow (set beats clear) and delivered-result counter next state.
    always_comb begin
        if (accept_s && arith_ovf_s) begin
            sticky_d = 1'b1;
        end else if (sticky_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
        count_d = count_q + {15'd0, deliver_s};
    end

    // Sticky flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= 16'd0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_s;
    assign out_result   = main_res_q;
    assign out_ctl      = main_ctl_q;
    assign out_overflow = main_ovf_q;
    assign out_zero     = main_zero_q;
    assign sticky_ovf   = sticky_q;
    assign result_count = count_q;

endmodule
